// File: rtl/templatized_alu_issue_queue.sv
// DEPTH-entry FIFO that buffers ALU ops and drops op codes the control decoder cannot decode.
// Optional occupancy statistics are compiled in with `define TEMPLATIZED_ALU_ISSUE_STATS_EN.
module templatized_alu_issue_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op_code,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 op_code,
    output logic [WIDTH-1:0]           out_a,
    output logic [WIDTH-1:0]           out_b,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       illegal_op
`ifdef TEMPLATIZED_ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]                issued_cnt,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [3:0] OP_IDLE = 4'b0011;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: is_legal = 1'b1;
            default:                                             is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [3:0]       op_mem_q [DEPTH];
    logic [WIDTH-1:0] a_mem_q  [DEPTH];
    logic [WIDTH-1:0] b_mem_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          illegal_q, illegal_d;

    logic push, push_legal, pop;

    // in_ready depends only on state and flush, never on out_ready
    assign in_ready   = (count_q != CW'(DEPTH)) && !flush;
    assign out_valid  = (count_q != '0);
    assign push       = in_valid && in_ready;
    assign push_legal = push && is_legal(in_op_code);
    assign pop        = out_valid && out_ready;

    assign op_code    = out_valid ? op_mem_q[rd_ptr_q] : OP_IDLE;
    assign out_a      = out_valid ? a_mem_q[rd_ptr_q]  : '0;
    assign out_b      = out_valid ? b_mem_q[rd_ptr_q]  : '0;
    assign count      = count_q;
    assign illegal_op = illegal_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        illegal_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            illegal_d = push && !push_legal;
            if (push_legal) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)        rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_legal, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage carries no reset; out_valid masks stale entries
    always_ff @(posedge clk) begin
        if (push_legal) begin
            op_mem_q[wr_ptr_q] <= in_op_code;
            a_mem_q[wr_ptr_q]  <= in_a;
            b_mem_q[wr_ptr_q]  <= in_b;
        end
    end

`ifdef TEMPLATIZED_ALU_ISSUE_STATS_EN
    logic [15:0] issued_q, issued_d;
    logic [15:0] stall_q,  stall_d;

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (flush) begin
            issued_d = '0;
            stall_d  = '0;
        end else begin
            if (pop)                     issued_d = sat_inc16(issued_q);
            if (out_valid && !out_ready) stall_d  = sat_inc16(stall_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign issued_cnt = issued_q;
    assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_templatized_alu_issue_queue.sv
// Bench for templatized_alu_issue_queue: directed vector table, hand sequences and random traffic
// against a queue-based reference model.
module tb_templatized_alu_issue_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op_code;
    logic [WIDTH-1:0] in_a, in_b;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] out_a, out_b;
    logic [CW-1:0]    count;
    logic             illegal_op;
`ifdef TEMPLATIZED_ALU_ISSUE_STATS_EN
    logic [15:0]      issued_cnt, stall_cnt;
`endif

    templatized_alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op_code(in_op_code),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .op_code(op_code),
        .out_a(out_a), .out_b(out_b), .count(count), .illegal_op(illegal_op)
`ifdef TEMPLATIZED_ALU_ISSUE_STATS_EN
        , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } ent_t;

    ent_t        mq[$];
    logic        ill_m;
    logic [15:0] iss_m, stall_m;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ill_m   = 1'b0;
        iss_m   = '0;
        stall_m = '0;
    endtask

    // Compare every output against the model, advance the model over one edge, then step the clock
    task automatic tick();
        bit do_pop, do_push, lg;
        ent_t e;
        #1;
        chk("in_ready",  in_ready,  (mq.size() != DEPTH) && !flush);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("count",     count,     mq.size());
        chk("op_code",   op_code,   mq.size() != 0 ? mq[0].op : 4'd3);
        chk("out_a",     out_a,     mq.size() != 0 ? mq[0].a  : '0);
        chk("out_b",     out_b,     mq.size() != 0 ? mq[0].b  : '0);
        chk("illegal",   illegal_op, ill_m);
`ifdef TEMPLATIZED_ALU_ISSUE_STATS_EN
        chk("issued_cnt", issued_cnt, iss_m);
        chk("stall_cnt",  stall_cnt,  stall_m);
`endif
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = in_valid && (mq.size() != DEPTH) && !flush;
        lg      = in_op_code inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        if (flush) begin
            mq.delete();
            ill_m   = 1'b0;
            iss_m   = '0;
            stall_m = '0;
        end else begin
            if (do_pop && iss_m != 16'hFFFF) iss_m++;
            if (mq.size() != 0 && !out_ready && stall_m != 16'hFFFF) stall_m++;
            if (do_pop) e = mq.pop_front();
            if (do_push && lg) mq.push_back('{in_op_code, in_a, in_b});
            ill_m = do_push && !lg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic r, input logic f);
        in_valid   = v;
        in_op_code = op;
        in_a       = a;
        in_b       = a + 100;
        out_ready  = r;
        flush      = f;
    endtask

    typedef struct {
        logic             vld;
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic             ordy;
        logic             e_rdy;
        int               e_cnt;
        logic             e_vld;
        logic [3:0]       e_op;
        logic [WIDTH-1:0] e_a;
        logic             e_ill;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic v, input logic [3:0] op, input int a, input logic r,
                                input logic erdy, input int ecnt, input logic evld,
                                input logic [3:0] eop, input int ea, input logic eill);
        vec_t t;
        t.vld = v; t.op = op; t.a = WIDTH'(a); t.ordy = r;
        t.e_rdy = erdy; t.e_cnt = ecnt; t.e_vld = evld; t.e_op = eop; t.e_a = WIDTH'(ea); t.e_ill = eill;
        return t;
    endfunction

    initial begin
        int ops[9] = '{0, 1, 2, 4, 5, 6, 7, 8, 9};

        // single op, fill/hold/drain, illegal drops
        tbl[0]  = mk(1, 5, 3,  0, 1, 1, 1, 5, 3,  0);
        tbl[1]  = mk(0, 0, 0,  0, 1, 1, 1, 5, 3,  0);
        tbl[2]  = mk(0, 0, 0,  1, 1, 0, 0, 3, 0,  0);
        tbl[3]  = mk(1, 0, 10, 0, 1, 1, 1, 0, 10, 0);
        tbl[4]  = mk(1, 1, 11, 0, 1, 2, 1, 0, 10, 0);
        tbl[5]  = mk(1, 2, 12, 0, 1, 3, 1, 0, 10, 0);
        tbl[6]  = mk(1, 4, 13, 0, 1, 4, 1, 0, 10, 0);
        tbl[7]  = mk(1, 7, 14, 0, 0, 4, 1, 0, 10, 0);
        tbl[8]  = mk(1, 7, 14, 1, 0, 3, 1, 1, 11, 0);
        tbl[9]  = mk(1, 7, 14, 0, 1, 4, 1, 1, 11, 0);
        tbl[10] = mk(0, 0, 0,  1, 0, 3, 1, 2, 12, 0);
        tbl[11] = mk(0, 0, 0,  1, 1, 2, 1, 4, 13, 0);
        tbl[12] = mk(0, 0, 0,  1, 1, 1, 1, 7, 14, 0);
        tbl[13] = mk(0, 0, 0,  1, 1, 0, 0, 3, 0,  0);
        tbl[14] = mk(1, 3, 20, 0, 1, 0, 0, 3, 0,  1);
        tbl[15] = mk(1, 15, 21, 0, 1, 0, 0, 3, 0, 1);
        tbl[16] = mk(1, 6, 22, 0, 1, 1, 1, 6, 22, 0);
        tbl[17] = mk(0, 0, 0,  0, 1, 1, 1, 6, 22, 0);
        tbl[18] = mk(0, 0, 0,  1, 1, 0, 0, 3, 0,  0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_code", op_code, 4'b0011);
        chk("rst_illegal", illegal_op, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].vld, tbl[i].op, tbl[i].a, tbl[i].ordy, 0);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            tick();
            chk($sformatf("vec%0d_count", i),     count,      tbl[i].e_cnt);
            chk($sformatf("vec%0d_out_valid", i), out_valid,  tbl[i].e_vld);
            chk($sformatf("vec%0d_op_code", i),   op_code,    tbl[i].e_op);
            chk($sformatf("vec%0d_out_a", i),     out_a,      tbl[i].e_a);
            chk($sformatf("vec%0d_illegal", i),   illegal_op, tbl[i].e_ill);
        end

        // simultaneous push/pop at count=2 across pointer wrap
        drive(1, 8, 30, 0, 0); tick();
        drive(1, 9, 31, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 4'(ops[$urandom_range(0, 8)]), 40 + i, 1, 0);
            tick();
            chk("simul_count", count, 2);
        end
        drive(0, 0, 0, 1, 0); tick(); tick();

        // flush with in_valid and a coinciding pop
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(ops[i]), 50 + i, 0, 0);
            tick();
        end
        drive(1, 1, 60, 1, 1);
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        drive(0, 0, 0, 0, 0);
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            tick();
        end

        // async reset between edges with a partly full queue
        drive(1, 5, 70, 0, 0); tick();
        drive(1, 6, 71, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_count", count, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_op_code", op_code, 4'b0011);
        chk("arst_out_a", out_a, 0);
        chk("arst_out_b", out_b, 0);
        chk("arst_illegal", illegal_op, 0);
`ifdef TEMPLATIZED_ALU_ISSUE_STATS_EN
        chk("arst_issued", issued_cnt, 0);
        chk("arst_stall", stall_cnt, 0);
`endif
        #2;
        rst_n = 1'b1;
        drive(1, 9, 80, 0, 0);
        tick();
        chk("post_rst_count", count, 1);
        chk("post_rst_op", op_code, 9);
        drive(0, 0, 0, 1, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
